// File: rtl/serial_link_pkg.sv
// Shared definitions for the processor's serial link (PISO serializer and SIPO deserializer).
//   piso_state_t  : serializer FSM state encoding
//   SERIAL_WORD_W : word width carried over the link
package serial_link_pkg;

   localparam int unsigned SERIAL_WORD_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

endpackage : serial_link_pkg

// File: rtl/piso_hold_buf.sv
// One-entry holding register with full flag, used by piso_serializer to park a word
// that arrives while the previous word is still shifting out.
// Ports:
//   clk, reset_b  : clock, synchronous active-low reset
//   fill          : capture data_in this edge
//   drain         : entry consumed this edge (fill and drain may coincide)
//   data_in       : word to park
//   data_out      : parked word
//   full          : entry holds a word (registered)
//   full_nxt_c    : value full takes at the next edge (combinational)
module piso_hold_buf
   import serial_link_pkg::*;
#(
   parameter int unsigned WIDTH = SERIAL_WORD_W
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             fill,
   input  logic             drain,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             full_nxt_c
);

   assign full_nxt_c = fill | (full & ~drain);

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         full     <= 1'b0;
         data_out <= '0;
      end else begin
         full <= full_nxt_c;
         if (fill) begin
            data_out <= data_in;
         end
      end
   end

endmodule : piso_hold_buf

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage feeding the SIPO deserializer. A word accepted over
// valid/ready is emitted as WIDTH consecutive valid bits, first bit one cycle later.
// Build option: define PISO_SERIALIZER_BUF_EN to add a one-entry holding register
// for zero-gap streaming; otherwise words are separated by one idle cycle.
// Ports:
//   clk, reset_b  : clock, synchronous active-low reset
//   data_in       : parallel word, sampled only on the transfer edge
//   in_valid      : data_in valid
//   in_ready      : word can be accepted (registered, no path from in_valid)
//   serial_out    : current bit, 0 when out_valid is low
//   out_valid     : serial_out carries a data bit
//   busy          : word shifting or buffered
module piso_serializer
   import serial_link_pkg::*;
#(
   parameter int unsigned WIDTH     = SERIAL_WORD_W,
   parameter bit          LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic [WIDTH-1:0] data_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             serial_out,
   output logic             out_valid,
   output logic             busy
);

   localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

   piso_state_t      state;
   piso_state_t      state_next;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_next;
   logic [WIDTH-1:0] load_data;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             load_c;
   logic             fire;
   logic             last;
   logic             ready_q, serial_q, valid_q, busy_q;
   logic             ready_next, serial_next, valid_next, busy_next;

   assign fire = in_valid & ready_q;
   assign last = (bit_cnt == CNT_W'(WIDTH - 1));

`ifdef PISO_SERIALIZER_BUF_EN
   logic             buf_fill;
   logic             buf_drain;
   logic             buf_full;
   logic             buf_full_nxt;
   logic [WIDTH-1:0] buf_data;

   piso_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
      .clk        (clk),
      .reset_b    (reset_b),
      .fill       (buf_fill),
      .drain      (buf_drain),
      .data_in    (data_in),
      .data_out   (buf_data),
      .full       (buf_full),
      .full_nxt_c (buf_full_nxt)
   );
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and word-load decision
   always_comb begin
      state_next = state;
      load_c     = 1'b0;
      load_data  = data_in;
`ifdef PISO_SERIALIZER_BUF_EN
      buf_fill   = 1'b0;
      buf_drain  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (fire) begin
               state_next = SHIFT;
               load_c     = 1'b1;
            end
         end
         SHIFT: begin
`ifdef PISO_SERIALIZER_BUF_EN
            if (last) begin
               // Parked word has priority; a word arriving on the last bit with an
               // empty buffer bypasses straight into the shift register.
               if (buf_full) begin
                  load_c    = 1'b1;
                  load_data = buf_data;
                  buf_drain = 1'b1;
                  buf_fill  = fire;
               end else if (fire) begin
                  load_c = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               buf_fill = fire;
            end
`else
            if (last) begin
               state_next = IDLE;
            end
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath next values and registered-output decode
   always_comb begin
      shreg_next = shreg;
      cnt_next   = bit_cnt;
      if (load_c) begin
         shreg_next = load_data;
         cnt_next   = '0;
      end else if (state == SHIFT) begin
         shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
         cnt_next   = bit_cnt + CNT_W'(1);
         if (state_next == IDLE) begin
            shreg_next = '0;
            cnt_next   = '0;
         end
      end
      valid_next  = (state_next == SHIFT);
      serial_next = valid_next & shreg_next[OUT_IDX];
`ifdef PISO_SERIALIZER_BUF_EN
      ready_next  = ~buf_full_nxt;
      busy_next   = valid_next | buf_full_nxt;
`else
      ready_next  = (state_next == IDLE);
      busy_next   = valid_next;
`endif
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         ready_q  <= 1'b0;
         serial_q <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         shreg    <= shreg_next;
         bit_cnt  <= cnt_next;
         ready_q  <= ready_next;
         serial_q <= serial_next;
         valid_q  <= valid_next;
         busy_q   <= busy_next;
      end
   end

   assign in_ready   = ready_q;
   assign serial_out = serial_q;
   assign out_valid  = valid_q;
   assign busy       = busy_q;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Directed and random checks of piso_serializer (MSB-first and LSB-first instances),
// with a bench-side SIPO model reassembling words from the serial stream.
module tb_piso_serializer;

   logic       clk = 1'b0;
   logic       reset_b;
   logic [7:0] data_in;
   logic       in_valid;
   logic       in_ready, serial_out, out_valid, busy;
   logic [7:0] l_data;
   logic       l_valid;
   logic       l_ready, l_serial, l_out_valid, l_busy;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piso_serializer u_dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .data_in    (data_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .serial_out (serial_out),
      .out_valid  (out_valid),
      .busy       (busy)
   );

   piso_serializer #(.LSB_FIRST(1'b1)) u_dut_lsb (
      .clk        (clk),
      .reset_b    (reset_b),
      .data_in    (l_data),
      .in_valid   (l_valid),
      .in_ready   (l_ready),
      .serial_out (l_serial),
      .out_valid  (l_out_valid),
      .busy       (l_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]  exp_a5;
      logic [7:0]  asm_w;
      logic [1:18] ev, es, er;
      int          nacc;
      logic        xfer;
      logic [7:0]  q[$];
      logic [7:0]  word, shw, exp_w;
      logic        pend;
      int          sent, rcvd, nbits;

      reset_b  = 1'b0;
      data_in  = 8'h00;
      in_valid = 1'b0;
      l_data   = 8'h00;
      l_valid  = 1'b0;
      step();
      step();
      chk("rst_serial_out", 32'(serial_out), 32'd0);
      chk("rst_out_valid",  32'(out_valid),  32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_in_ready",   32'(in_ready),   32'd0);
      chk("rst_lsb_valid",  32'(l_out_valid), 32'd0);
      reset_b = 1'b1;
      step();
      chk("rel_in_ready",   32'(in_ready),   32'd1);
      chk("rel_lsb_ready",  32'(l_ready),    32'd1);

      // 0xA5 MSB-first: bits 1,0,1,0,0,1,0,1 in cycles t+1..t+8
      exp_a5   = 8'b1010_0101;
      data_in  = 8'hA5;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      data_in  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("a5_valid%0d", i),  32'(out_valid),  32'd1);
         chk($sformatf("a5_bit%0d", i),    32'(serial_out), 32'(exp_a5[7-i]));
         chk($sformatf("a5_busy%0d", i),   32'(busy),       32'd1);
`ifdef PISO_SERIALIZER_BUF_EN
         chk($sformatf("a5_ready%0d", i),  32'(in_ready),   32'd1);
`else
         chk($sformatf("a5_ready%0d", i),  32'(in_ready),   32'd0);
`endif
         step();
      end
      chk("a5_end_valid",  32'(out_valid),  32'd0);
      chk("a5_end_serial", 32'(serial_out), 32'd0);
      chk("a5_end_busy",   32'(busy),       32'd0);
      chk("a5_end_ready",  32'(in_ready),   32'd1);

      // 0x01 LSB-first: bits 1,0,0,0,0,0,0,0; SIPO loopback rebuilds 0x01
      l_data  = 8'h01;
      l_valid = 1'b1;
      step();
      l_valid = 1'b0;
      l_data  = 8'hFF;
      asm_w   = 8'h00;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("lsb_valid%0d", i), 32'(l_out_valid), 32'd1);
         chk($sformatf("lsb_bit%0d", i),   32'(l_serial),    (i == 0) ? 32'd1 : 32'd0);
         asm_w[i] = l_serial;
         step();
      end
      chk("lsb_end_valid", 32'(l_out_valid), 32'd0);
      chk("lsb_loopback",  32'(asm_w),       32'h01);

      // 0x3C then 0xC3 with in_valid held; the second word is held during SHIFT
`ifdef PISO_SERIALIZER_BUF_EN
      ev = 18'b11111111_11111111_00;
      es = 18'b00111100_11000011_00;
      er = 18'b1_0000000_1111111111;
`else
      ev = 18'b11111111_0_11111111_0;
      es = 18'b00111100_0_11000011_0;
      er = 18'b00000000_1_00000000_1;
`endif
      data_in  = 8'h3C;
      in_valid = 1'b1;
      nacc     = 0;
      for (int c = 1; c <= 18; c++) begin
         xfer = in_valid & in_ready;
         step();
         if (xfer) begin
            nacc++;
            if (nacc == 1) data_in = 8'hC3;
            else begin
               in_valid = 1'b0;
               data_in  = 8'h00;
            end
         end
         chk($sformatf("b2b_valid_c%0d", c),  32'(out_valid),  32'(ev[c]));
         chk($sformatf("b2b_serial_c%0d", c), 32'(serial_out), 32'(es[c]));
         chk($sformatf("b2b_ready_c%0d", c),  32'(in_ready),   32'(er[c]));
      end
      chk("b2b_accepted", 32'(nacc), 32'd2);
      in_valid = 1'b0;

      // Reset asserted at bit 4 of 0xFF discards the partial word
      data_in  = 8'hFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      data_in  = 8'h00;
      for (int i = 0; i < 4; i++) step();
      chk("rstmid_bit4_valid",  32'(out_valid),  32'd1);
      chk("rstmid_bit4_serial", 32'(serial_out), 32'd1);
      reset_b = 1'b0;
      step();
      chk("rstmid_valid",  32'(out_valid),  32'd0);
      chk("rstmid_serial", 32'(serial_out), 32'd0);
      chk("rstmid_ready",  32'(in_ready),   32'd0);
      chk("rstmid_busy",   32'(busy),       32'd0);
      reset_b = 1'b1;
      step();
      chk("rstmid_rel_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("rstmid_resid_valid%0d", i),  32'(out_valid),  32'd0);
         chk($sformatf("rstmid_resid_serial%0d", i), 32'(serial_out), 32'd0);
         step();
      end

      // Random 1000-word stream into the bench SIPO model with a scoreboard
      pend  = 1'b0;
      word  = 8'h00;
      shw   = 8'h00;
      sent  = 0;
      rcvd  = 0;
      nbits = 0;
      for (int cyc = 0; cyc < 30000 && rcvd < 1000; cyc++) begin
         if (!pend && sent < 1000 && $urandom_range(0, 3) != 0) begin
            pend = 1'b1;
            word = 8'($urandom);
         end
         in_valid = pend;
         data_in  = word;
         if (pend && in_ready) begin
            q.push_back(word);
            pend = 1'b0;
            sent++;
         end
         step();
         if (out_valid) begin
            shw = {shw[6:0], serial_out};
            nbits++;
            if (nbits == 8) begin
               nbits = 0;
               rcvd++;
               if (q.size() > 0) exp_w = q.pop_front();
               else exp_w = 8'hxx;
               chk($sformatf("rnd_word%0d", rcvd), 32'(shw), 32'(exp_w));
            end
         end else if (nbits != 0) begin
            chk("rnd_short_burst", 32'(nbits), 32'd0);
            nbits = 0;
         end
      end
      in_valid = 1'b0;
      chk("rnd_words_received", 32'(rcvd), 32'd1000);
      chk("rnd_queue_empty",    32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_piso_serializer
